// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM state encodings
// and helpers for byte-strobe merging and word-address decode.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest supported bus; helpers work at this width and callers slice down.
    localparam int unsigned MAX_DATA_WIDTH = 64;

    typedef enum logic {
        W_IDLE,     // collecting AW and W beats
        W_RESP      // BVALID asserted, waiting for BREADY
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,     // ARREADY asserted
        R_ADDR,     // address held, data sampled on the next edge
        R_DATA      // RVALID asserted, waiting for RREADY
    } rd_state_e;

    // Number of byte-offset bits below the word index.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Replace the byte lanes of old_val selected by wstrb with wdata lanes.
    function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
        input logic [MAX_DATA_WIDTH-1:0]   old_val,
        input logic [MAX_DATA_WIDTH-1:0]   wdata,
        input logic [MAX_DATA_WIDTH/8-1:0] wstrb
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH / 8; i++) begin
            merged[i*8 +: 8] = wstrb[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave register bank.
// NUM_REGS word-wide registers with byte-strobe writes. Registers flagged in
// RO_MASK are read-only and return the matching status_in slice; writes to
// them, or to addresses past the bank, get SLVERR. Write and read channels
// run independently, each handling one transaction at a time.
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   AW*/W*/B*             write address, data and response channels
//   AR*/R*                read address and data channels
//   reg_out               flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse              one-cycle strobe per register after a committed write
//   status_in             read source for read-only registers
module axi4_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           ADDRESS_WIDTH = 32,
    parameter int unsigned           NUM_REGS      = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK       = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);

    localparam int unsigned LSB    = addr_lsb(DATA_WIDTH);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);

    // Protection bits carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    // ---------------- write channel state ----------------
    wr_state_e                 w_state_q, w_state_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [ADDRESS_WIDTH-1:0]  aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
    logic [STRB_W-1:0]         w_strb_q, w_strb_d;
    logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];

    // ---------------- read channel state ----------------
    rd_state_e                 r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [ADDRESS_WIDTH-1:0]  ar_addr_q, ar_addr_d;

    // ---------------- address decode ----------------
    logic [ADDRESS_WIDTH-1:0]  aw_word, ar_word;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      wr_in_range, rd_in_range, wr_ok;

    assign aw_word     = aw_addr_q >> LSB;
    assign ar_word     = ar_addr_q >> LSB;
    assign wr_in_range = aw_word < ADDRESS_WIDTH'(NUM_REGS);
    assign rd_in_range = ar_word < ADDRESS_WIDTH'(NUM_REGS);
    assign wr_idx      = aw_word[IDX_W-1:0];
    assign rd_idx      = ar_word[IDX_W-1:0];
    assign wr_ok       = wr_in_range && !RO_MASK[wr_idx];

    // Strobe merge runs at the package's maximum width.
    logic [MAX_DATA_WIDTH-1:0]   old_ext, wdata_ext, merged;
    logic [MAX_DATA_WIDTH/8-1:0] strb_ext;

    always_comb begin
        old_ext   = '0;
        wdata_ext = '0;
        strb_ext  = '0;
        old_ext[DATA_WIDTH-1:0]  = regs_q[wr_idx];
        wdata_ext[DATA_WIDTH-1:0] = w_data_q;
        strb_ext[STRB_W-1:0]     = w_strb_q;
        merged = strb_merge(old_ext, wdata_ext, strb_ext);
    end

    // Status words as an array for indexed read.
    logic [DATA_WIDTH-1:0] status_w [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slots
        assign status_w[g] = status_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
    end

    // ---------------- write channel next state ----------------
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    if (wr_ok) begin
                        regs_d[wr_idx]     = merged[DATA_WIDTH-1:0];
                        wr_pulse_d[wr_idx] = 1'b1;
                        bresp_d            = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (AWVALID && awready_q) begin
                        aw_held_d = 1'b1;
                        aw_addr_d = AWADDR;
                    end
                    if (WVALID && wready_q) begin
                        w_held_d = 1'b1;
                        w_data_d = WDATA;
                        w_strb_d = WSTRB;
                    end
                    // READY follows the held flag so each beat is taken once.
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_pulse_q <= '0;
            regs_q     <= '{default: '0};
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // ---------------- read channel next state ----------------
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        ar_addr_d = ar_addr_q;

        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && arready_q) begin
                    ar_addr_d = ARADDR;
                    arready_d = 1'b0;
                    r_state_d = R_ADDR;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_ADDR: begin
                // regs_q is the pre-commit value if a write lands this edge.
                if (rd_in_range) begin
                    rdata_d = RO_MASK[rd_idx] ? status_w[rd_idx] : regs_q[rd_idx];
                    rresp_d = RESP_OKAY;
                end else begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
                rvalid_d  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            ar_addr_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            ar_addr_q <= ar_addr_d;
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign wr_pulse = wr_pulse_q;

endmodule
